// File: rtl/ascon_ti_pkg.sv
// Shared types, rotation amounts and round-constant helper for the three-share
// threshold-implementation Ascon permutation engine.
package ascon_ti_pkg;

  localparam int unsigned LaneW     = 64;
  localparam int unsigned NumShares = 3;
  localparam int unsigned MaxRounds = 12;

  // Linear-layer right-rotation amounts, two per lane.
  localparam int unsigned Rot0A = 19;
  localparam int unsigned Rot0B = 28;
  localparam int unsigned Rot1A = 61;
  localparam int unsigned Rot1B = 39;
  localparam int unsigned Rot2A = 1;
  localparam int unsigned Rot2B = 6;
  localparam int unsigned Rot3A = 10;
  localparam int unsigned Rot3B = 17;
  localparam int unsigned Rot4A = 7;
  localparam int unsigned Rot4B = 41;

  typedef logic [LaneW-1:0] lane_t;

  // x0 occupies the most significant lane, matching the port packing.
  typedef struct packed {
    lane_t x0;
    lane_t x1;
    lane_t x2;
    lane_t x3;
    lane_t x4;
  } state_t;

  typedef state_t [NumShares-1:0] shares_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } fsm_e;

  function automatic lane_t ror(input lane_t x, input int unsigned n);
    return (x >> n) | (x << (LaneW - n));
  endfunction

  function automatic lane_t round_const(input logic [3:0] rnd);
    logic [3:0] hi;
    hi = 4'hF - rnd;
    return {{(LaneW - 8){1'b0}}, hi, rnd};
  endfunction

endpackage

// File: rtl/ascon_ti_sbox_slice.sv
// One column of the three-share TI Ascon S-box. Bit k of each share vector is lane xk.
// Output share j depends only on input shares j+1 and j+2 (mod 3), so no share is recombined.
module ascon_ti_sbox_slice (
  input  logic [4:0] in_s0,
  input  logic [4:0] in_s1,
  input  logic [4:0] in_s2,
  output logic [4:0] out_s0,
  output logic [4:0] out_s1,
  output logic [4:0] out_s2
);

  // Affine input layer: x0^=x4, x4^=x3, x2^=x1.
  function automatic logic [4:0] pre(input logic [4:0] x);
    return {x[4] ^ x[3], x[3], x[2] ^ x[1], x[1], x[0] ^ x[4]};
  endfunction

  // Shared chi: a_k ^ (~a_{k+1} & a_{k+2}); p supplies the linear part and the
  // p*p, p*q, q*p cross products of the AND.
  function automatic logic [4:0] chi_share(input logic [4:0] p, input logic [4:0] q);
    logic [4:0] r;
    for (int k = 0; k < 5; k++) begin
      r[k] = p[k] ^ p[(k + 2) % 5]
           ^ (p[(k + 1) % 5] & p[(k + 2) % 5])
           ^ (p[(k + 1) % 5] & q[(k + 2) % 5])
           ^ (q[(k + 1) % 5] & p[(k + 2) % 5]);
    end
    return r;
  endfunction

  // Affine output layer; the final inversion of x2 lands on one share only.
  function automatic logic [4:0] post(input logic [4:0] c, input logic inv);
    return {c[4], c[3] ^ c[2], c[2] ^ inv, c[1] ^ c[0], c[0] ^ c[4]};
  endfunction

  logic [4:0] a0, a1, a2;

  assign a0 = pre(in_s0);
  assign a1 = pre(in_s1);
  assign a2 = pre(in_s2);

  assign out_s0 = post(chi_share(a1, a2), 1'b1);
  assign out_s1 = post(chi_share(a2, a0), 1'b0);
  assign out_s2 = post(chi_share(a0, a1), 1'b0);

endmodule

// File: rtl/ascon_ti_round_engine.sv
// Three-share TI Ascon permutation engine: one masked round per cycle, with the
// share registers acting as the glitch barrier between S-box layers.
module ascon_ti_round_engine
  import ascon_ti_pkg::*;
#(
  parameter int unsigned W = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [5*W-1:0] in_s0,
  input  logic [5*W-1:0] in_s1,
  input  logic [5*W-1:0] in_s2,
  input  logic [3:0]     in_rounds,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [5*W-1:0] out_s0,
  output logic [5*W-1:0] out_s1,
  output logic [5*W-1:0] out_s2
);

  fsm_e       state_q, state_d;
  shares_t    shares_q, shares_d;
  logic [3:0] rnd_q, rnd_d;
  logic [3:0] rounds_eff;

  shares_t    sb_in, sb_out, lin_out;
  logic [4:0] col_in  [NumShares][W];
  logic [4:0] col_out [NumShares][W];

  function automatic state_t linear(input state_t s);
    state_t r;
    r.x0 = s.x0 ^ ror(s.x0, Rot0A) ^ ror(s.x0, Rot0B);
    r.x1 = s.x1 ^ ror(s.x1, Rot1A) ^ ror(s.x1, Rot1B);
    r.x2 = s.x2 ^ ror(s.x2, Rot2A) ^ ror(s.x2, Rot2B);
    r.x3 = s.x3 ^ ror(s.x3, Rot3A) ^ ror(s.x3, Rot3B);
    r.x4 = s.x4 ^ ror(s.x4, Rot4A) ^ ror(s.x4, Rot4B);
    return r;
  endfunction

  assign rounds_eff = (in_rounds == 4'd0 || in_rounds > 4'(MaxRounds)) ? 4'(MaxRounds)
                                                                       : in_rounds;

  // Constant is added to share 0 only; the other shares carry masks alone.
  always_comb begin
    sb_in       = shares_q;
    sb_in[0].x2 = shares_q[0].x2 ^ round_const(rnd_q);
  end

  always_comb begin
    for (int unsigned s = 0; s < NumShares; s++) begin
      for (int unsigned i = 0; i < W; i++) begin
        col_in[s][i] = {sb_in[s].x4[i], sb_in[s].x3[i], sb_in[s].x2[i],
                        sb_in[s].x1[i], sb_in[s].x0[i]};
      end
    end
  end

  for (genvar i = 0; i < W; i++) begin : g_col
    ascon_ti_sbox_slice u_slice (
      .in_s0  (col_in[0][i]),
      .in_s1  (col_in[1][i]),
      .in_s2  (col_in[2][i]),
      .out_s0 (col_out[0][i]),
      .out_s1 (col_out[1][i]),
      .out_s2 (col_out[2][i])
    );
  end

  always_comb begin
    sb_out = '0;
    for (int unsigned s = 0; s < NumShares; s++) begin
      for (int unsigned i = 0; i < W; i++) begin
        sb_out[s].x0[i] = col_out[s][i][0];
        sb_out[s].x1[i] = col_out[s][i][1];
        sb_out[s].x2[i] = col_out[s][i][2];
        sb_out[s].x3[i] = col_out[s][i][3];
        sb_out[s].x4[i] = col_out[s][i][4];
      end
    end
    for (int unsigned s = 0; s < NumShares; s++) begin
      lin_out[s] = linear(sb_out[s]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StRun;
      StRun:   if (rnd_q == 4'd11) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  always_comb begin
    shares_d = shares_q;
    rnd_d    = rnd_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          shares_d[0] = in_s0;
          shares_d[1] = in_s1;
          shares_d[2] = in_s2;
          rnd_d       = 4'(MaxRounds) - rounds_eff;
        end
      end
      StRun: begin
        shares_d = lin_out;
        rnd_d    = rnd_q + 4'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shares_q <= '0;
      rnd_q    <= '0;
    end else begin
      shares_q <= shares_d;
      rnd_q    <= rnd_d;
    end
  end

  assign out_s0 = shares_q[0];
  assign out_s1 = shares_q[1];
  assign out_s2 = shares_q[2];

endmodule

// File: tb/tb_ascon_ti_round_engine.sv
// Directed bench for the TI Ascon round engine: recombined outputs against an
// unmasked reference permutation, plus latency, backpressure and reset sequences.
module tb_ascon_ti_round_engine;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [319:0] in_s0, in_s1, in_s2;
  logic [3:0]   in_rounds;
  logic         out_valid;
  logic         out_ready;
  logic [319:0] out_s0, out_s1, out_s2;

  int checks = 0;
  int errors = 0;

  ascon_ti_round_engine #(.W(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_s0     (in_s0),
    .in_s1     (in_s1),
    .in_s2     (in_s2),
    .in_rounds (in_rounds),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s0    (out_s0),
    .out_s1    (out_s1),
    .out_s2    (out_s2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string        name;
    logic [3:0]   rounds_in;
    int           model_rounds;
    logic [7:0]   first_const;
    logic [319:0] state;
    logic [319:0] m1;
    logic [319:0] m2;
  } vec_t;

  localparam logic [319:0] Pat = {5{64'h0123456789ABCDEF}};
  localparam logic [319:0] MA1 = {64'h243F6A8885A308D3, 64'h13198A2E03707344,
                                  64'hA4093822299F31D0, 64'h082EFA98EC4E6C89,
                                  64'h452821E638D01377};
  localparam logic [319:0] MA2 = {64'hBE5466CF34E90C6C, 64'hC0AC29B7C97C50DD,
                                  64'h3F84D5B5B5470917, 64'h9216D5D98979FB1B,
                                  64'hD1310BA698DFB5AC};
  localparam logic [319:0] MB1 = {64'h2FFD72DBD01ADFB7, 64'hB8E1AFED6A267E96,
                                  64'hBA7C9045F12C7F99, 64'h24A19947B3916CF7,
                                  64'h0801F2E2858EFC16};
  localparam logic [319:0] MB2 = {64'h636920D871574E69, 64'hA458FEA3F4933D7E,
                                  64'h0D95748F728EB658, 64'h718BCD5882154AEE,
                                  64'h7B54A41DC25A59B5};

  vec_t vecs[8];

  function automatic vec_t mk(input string nm, input logic [3:0] ri, input int mr,
                              input logic [7:0] c0, input logic [319:0] st,
                              input logic [319:0] a, input logic [319:0] b);
    vec_t v;
    v.name = nm; v.rounds_in = ri; v.model_rounds = mr; v.first_const = c0;
    v.state = st; v.m1 = a; v.m2 = b;
    return v;
  endfunction

  function automatic logic [63:0] rr(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  // Unmasked reference permutation; constants step down by 0x0F from c0.
  function automatic logic [319:0] ascon_ref(input logic [319:0] s, input int n,
                                             input logic [7:0] c0);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    logic [7:0]  c;
    {x0, x1, x2, x3, x4} = s;
    c = c0;
    for (int r = 0; r < n; r++) begin
      x2 = x2 ^ {56'h0, c};
      x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
      x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
      x0 = x0 ^ rr(x0, 19) ^ rr(x0, 28);
      x1 = x1 ^ rr(x1, 61) ^ rr(x1, 39);
      x2 = x2 ^ rr(x2, 1)  ^ rr(x2, 6);
      x3 = x3 ^ rr(x3, 10) ^ rr(x3, 17);
      x4 = x4 ^ rr(x4, 7)  ^ rr(x4, 41);
      c = c - 8'h0F;
    end
    return {x0, x1, x2, x3, x4};
  endfunction

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_ne(input string nm, input logic [319:0] a, input logic [319:0] b);
    checks++;
    if (a === b) begin
      errors++;
      $display("FAIL %s: got %h expected a different value", nm, a);
    end
  endtask

  task automatic launch(input vec_t v);
    chk({v.name, " in_ready idle"}, 320'(in_ready), 320'(1));
    in_s0     = v.state ^ v.m1 ^ v.m2;
    in_s1     = v.m1;
    in_s2     = v.m2;
    in_rounds = v.rounds_in;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    chk({v.name, " in_ready run"}, 320'(in_ready), 320'(0));
  endtask

  // Returns the cycle index of out_valid counting the handshake cycle as 0.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid after handoff", 320'(out_valid), 320'(0));
    chk("in_ready after handoff", 320'(in_ready), 320'(1));
  endtask

  task automatic run_op(input vec_t v, output logic [319:0] o1);
    int lat;
    launch(v);
    wait_done(lat);
    chk({v.name, " latency"}, 320'(lat), 320'(v.model_rounds + 1));
    chk({v.name, " result"}, out_s0 ^ out_s1 ^ out_s2,
        ascon_ref(v.state, v.model_rounds, v.first_const));
    o1 = out_s1;
    release_out();
  endtask

  initial begin
    logic [319:0] o1, o1_first, hold0, hold2, exp;
    int           lat;

    vecs[0] = mk("zero r12", 4'd12, 12, 8'hF0, '0, '0, '0);
    vecs[1] = mk("pat r12 maskA", 4'd12, 12, 8'hF0, Pat, MA1, MA2);
    vecs[2] = mk("pat r12 maskB", 4'd12, 12, 8'hF0, Pat, MB1, MB2);
    vecs[3] = mk("pat r6", 4'd6, 6, 8'h96, Pat, MA1, MB2);
    vecs[4] = mk("pat r8", 4'd8, 8, 8'hB4, Pat, MB1, MA2);
    vecs[5] = mk("rounds0", 4'd0, 12, 8'hF0, Pat, MA2, MB1);
    vecs[6] = mk("rounds15", 4'd15, 12, 8'hF0, Pat, MB2, MA1);
    vecs[7] = mk("r1 masked", 4'd1, 1, 8'h4B, MA1, MB1, MB2);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_s0 = '0; in_s1 = '0; in_s2 = '0; in_rounds = 4'd0;
    #1;
    chk("reset in_ready", 320'(in_ready), 320'(1));
    chk("reset out_valid", 320'(out_valid), 320'(0));
    chk("reset out_s0", out_s0, '0);
    chk("reset out_s1^s2", out_s1 | out_s2, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    o1_first = '0;
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i], o1);
      if (i == 1) o1_first = o1;
      if (i == 2) chk_ne("remask share1 differs", o1, o1_first);
    end

    // Backpressure: result must hold and a stray in_valid must be ignored.
    launch(vecs[4]);
    wait_done(lat);
    chk("bp latency", 320'(lat), 320'(9));
    exp   = ascon_ref(vecs[4].state, 8, 8'hB4);
    hold0 = out_s0;
    hold2 = out_s2;
    for (int c = 0; c < 20; c++) begin
      if (c == 10) begin
        in_s0 = ~Pat; in_s1 = MB1; in_s2 = MB2; in_rounds = 4'd1; in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp out_s0 stable", out_s0, hold0);
      chk("bp out_s2 stable", out_s2, hold2);
      chk("bp in_ready low", 320'(in_ready), 320'(0));
      chk("bp out_valid high", 320'(out_valid), 320'(1));
    end
    chk("bp result", out_s0 ^ out_s1 ^ out_s2, exp);
    release_out();
    @(posedge clk); #1;
    chk("bp pulse ignored", 320'(in_ready), 320'(1));

    // Reset in the middle of a run, then a clean operation.
    launch(vecs[1]);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst in_ready", 320'(in_ready), 320'(1));
    chk("midrst out_valid", 320'(out_valid), 320'(0));
    chk("midrst out_s0", out_s0, '0);
    chk("midrst out_s1", out_s1, '0);
    chk("midrst out_s2", out_s2, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(vecs[2], o1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ascon_ti_round_engine.md
# ascon_ti_round_engine

Three-share threshold-implementation Ascon permutation engine. It holds a 3-share 320-bit state and, each cycle, applies one full masked round to every share: constant addition, TI S-box layer and linear diffusion. The state register is the glitch barrier between successive nonlinear layers. Masked shares arrive from the share-split stage; results go to the AEAD mode controller, which recombines only tag/ciphertext words.

## Interface

Parameters:
- `W`, 64: lane width. Fixed to 64 for Ascon; exists only for package reuse.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `in_valid`  in  1  — input state shares and round count are valid.
- `in_ready`  out  1  — engine can accept a new state.
- `in_s0`, `in_s1`, `in_s2`  in  320 each  — input shares. Bits [319:256] = x0 … [63:0] = x4.
- `in_rounds`  in  4  — number of rounds to run, 1..12.
- `out_valid`  out  1  — result shares are valid.
- `out_ready`  in  1  — consumer accepts the result.
- `out_s0`, `out_s1`, `out_s2`  out  320 each  — result shares, same packing as the input shares.

## Operation

- FSM has three states: IDLE, RUN and DONE. Reset state is IDLE.
- **Reset values:** `in_ready`=1, `out_valid`=0, all share registers 0, round counter 0. Reset is asynchronous and aborts any operation in progress; the partial state is discarded.
- **IDLE:** `in_ready`=1. On `in_valid`:
  - Register all three shares.
  - Load `rnd` = 12 − R, where R = `in_rounds`. Values of `in_rounds` equal to 0 or 13..15 are treated as R = 12.
  - Go to RUN.
- **RUN:** `in_ready`=0 and `out_valid`=0. Each cycle performs one round:
  - Constant addition: x2 of share 0 only is XORed with c = {(4'hF − rnd[3:0]), rnd[3:0]}, zero-extended to 64 bits. Shares 1 and 2 get no constant.
  - S-box layer: 64 column slices. Column i takes bit i of x0..x4 from each share and produces 3 output shares. The slices are combinational TI equations, with no fresh randomness.
  - Linear layer, applied per share independently. All rotations are right rotations (ror):
    - x0 ^= ror19 ^ ror28
    - x1 ^= ror61 ^ ror39
    - x2 ^= ror1 ^ ror6
    - x3 ^= ror10 ^ ror17
    - x4 ^= ror7 ^ ror41
  - The result is written back to the share registers and `rnd` increments.
  - When the round with `rnd` = 11 is written, go to DONE.
- **DONE:** `out_valid`=1 and the outputs are stable. The engine holds while `out_ready`=0. On `out_ready`=1, go to IDLE.
- A new input is never accepted in the same cycle as the output handshake. `in_valid` is ignored outside IDLE.
- `out_s*` are driven directly from the share registers. In states other than DONE their value is don't-care, but unmasked data must never appear on any wire.

## Timing

- Input handshake: cycle T.
- R round cycles: T+1..T+R.
- `out_valid` rises at T+R+1.
- Minimum issue interval: R+2 cycles (load, R rounds, handoff cycle, return to IDLE).
- The critical path is one S-box slice plus a 3-input linear XOR plus the constant XOR.
- Nonlinear inputs always come straight from registers. No two S-box layers appear in one combinational cone.

## Structure

- Package `ascon_ti_pkg` holds:
  - the `state_t` typedef (5×64 lane array) and `shares_t` typedef (3×`state_t`);
  - the rotation-amount constants;
  - `round_const(rnd)`;
  - the FSM state enum.
- Sub-module `ascon_ti_sbox_slice`: 15 single-bit inputs (x0..x4 × 3 shares) and 15 outputs. It is combinational, contains the TI equations, and is instantiated 64 times via generate.
- The linear layer and the FSM/counter live in the top level.

## Test plan

Every check compares recombined outputs (s0^s1^s2) against an unmasked golden Ascon-p model.

- **All-zero state, R=12, zero masks:** s0=0, s1=0, s2=0.
  - Recombined result equals p12(0).
  - `out_valid` rises exactly 13 cycles after the input handshake.
- **Random masking, R=12:** state = 0x0123…CDEF repeated, masks s1 and s2 random.
  - Recombined result equals the golden model.
  - A second run with different masks on the same state gives an identical recombined result and different individual shares.
- **R=6 and R=8:**
  - Round constants start at 0x96 and 0xB4 respectively.
  - Recombined output matches p6 and p8; latency is 7 and 9 cycles.
- **`in_rounds`=0 and 15:** behaviour is identical to R=12, including latency and result.
- **Backpressure:** hold `out_ready`=0 for 20 cycles.
  - Outputs stay stable.
  - `in_ready` stays 0.
  - A pulse of `in_valid` during that window is ignored.
- **Reset mid-RUN:** assert `rst_n`=0 at round 5.
  - All outputs take their reset values immediately.
  - After release, a fresh R=12 operation completes correctly.
